// File: rtl/adder_pkg.sv
// Shared definitions for adder_pipe: flag bit positions, op encodings, flag vector type.
// The optional signed-saturation feature is enabled with the ADDER_SAT_EN macro.
package adder_pkg;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [3:0] adder_flags_t;
endpackage

// File: rtl/adder_chunk.sv
// One pipeline slice of adder_pipe: registers a CW-bit chunk sum and its carry-out.
// Holds its contents whenever en_i is low.
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o
);
    logic [CW:0]   sum_d;
    logic [CW-1:0] s_q;
    logic          c_q;

    assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else if (en_i) begin
            s_q <= sum_d[CW-1:0];
            c_q <= sum_d[CW];
        end
    end

    assign s_o = s_q;
    assign c_o = c_q;
endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub with carry rippling one chunk per stage, valid/ready handshake and flags.
// Define ADDER_SAT_EN to add the sat port and signed saturation in the final stage.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             cin,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output adder_flags_t     flags
);
    localparam int CW = WIDTH / STAGES;

    logic                       adv;
    logic [WIDTH-1:0]           b_eff;
    logic [STAGES-1:0]          vld_q;
    logic [STAGES-1:0]          c_q;
    logic [STAGES-1:0][CW-1:0]  s_q;
    logic [WIDTH-1:0]           raw;
    logic [WIDTH-1:0]           res;
    logic                       am_q, bm_q;
    logic                       ovf;
`ifdef ADDER_SAT_EN
    logic [STAGES-1:0]          sat_q;
`endif

    // One advance signal for the whole pipe: bubbles hold too, so outputs stay frozen on stall.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (op_sub == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [CW-1:0] ca, cb;
        logic          ci;

        if (k == 0) begin : g_src
            assign ca = a[CW-1:0];
            assign cb = b_eff[CW-1:0];
            assign ci = cin ^ op_sub;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q[k] <= 1'b0;
`ifdef ADDER_SAT_EN
                    sat_q[k] <= 1'b0;
`endif
                end else if (adv) begin
                    vld_q[k] <= in_valid;
`ifdef ADDER_SAT_EN
                    sat_q[k] <= sat;
`endif
                end
            end
        end else begin : g_src
            assign ca = stg[k-1].g_fwd.a_up_q[CW-1:0];
            assign cb = stg[k-1].g_fwd.b_up_q[CW-1:0];
            assign ci = c_q[k-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q[k] <= 1'b0;
`ifdef ADDER_SAT_EN
                    sat_q[k] <= 1'b0;
`endif
                end else if (adv) begin
                    vld_q[k] <= vld_q[k-1];
`ifdef ADDER_SAT_EN
                    sat_q[k] <= sat_q[k-1];
`endif
                end
            end
        end

        adder_chunk #(.CW(CW)) u_chunk (
            .clk  (clk),
            .rst  (rst),
            .en_i (adv),
            .a_i  (ca),
            .b_i  (cb),
            .c_i  (ci),
            .s_o  (s_q[k]),
            .c_o  (c_q[k])
        );

        // Operand chunks not yet summed ride along, shrinking by one chunk per stage.
        if (k < STAGES-1) begin : g_fwd
            localparam int UW = WIDTH - (k+1)*CW;
            logic [UW-1:0] a_up_d, b_up_d, a_up_q, b_up_q;
            if (k == 0) begin : g_d
                assign a_up_d = a[WIDTH-1:CW];
                assign b_up_d = b_eff[WIDTH-1:CW];
            end else begin : g_d
                assign a_up_d = stg[k-1].g_fwd.a_up_q[UW+CW-1:CW];
                assign b_up_d = stg[k-1].g_fwd.b_up_q[UW+CW-1:CW];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (adv) begin
                    a_up_q <= a_up_d;
                    b_up_q <= b_up_d;
                end
            end
        end

        if (k > 0) begin : g_lo
            logic [k*CW-1:0] lo_d, lo_q;
            if (k == 1) begin : g_lod
                assign lo_d = s_q[0];
            end else begin : g_lod
                assign lo_d = {s_q[k-1], stg[k-1].g_lo.lo_q};
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      lo_q <= '0;
                else if (adv) lo_q <= lo_d;
            end
        end

        if (k == STAGES-1) begin : g_last
            // Operand sign bits are kept for the overflow test after the last chunk lands.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    am_q <= 1'b0;
                    bm_q <= 1'b0;
                end else if (adv) begin
                    am_q <= ca[CW-1];
                    bm_q <= cb[CW-1];
                end
            end
            if (k == 0) begin : g_raw
                assign raw = s_q[k];
            end else begin : g_raw
                assign raw = {s_q[k], g_lo.lo_q};
            end
        end
    end

    assign ovf = (am_q == bm_q) && (raw[WIDTH-1] != am_q);

`ifdef ADDER_SAT_EN
    assign res = (sat_q[STAGES-1] && ovf)
               ? (am_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : raw;
`else
    assign res = raw;
`endif

    assign r         = res;
    assign out_valid = vld_q[STAGES-1];

    always_comb begin
        flags = '0;
        if (out_valid) begin
            flags[FLAG_C] = c_q[STAGES-1];
            flags[FLAG_V] = ovf;
            flags[FLAG_Z] = (res == '0);
            flags[FLAG_N] = res[WIDTH-1];
        end
    end
endmodule
